// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC owner, single-outstanding imem requester
// and IF/ID pipeline register with stall, flush and in-flight squash.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iStall,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPC,
  output logic        oIMemReq,
  output logic [31:0] oIMemAddr,
  input  logic        iIMemAck,
  input  logic [31:0] iIMemData,
  output logic [31:0] oIF_ID_ppInstr,
  output logic [31:0] oIF_ID_ppPC4,
  output logic        oIF_ID_ppValid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    BUF   = 2'd2,
    DROP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] tgt_q, tgt_d;

  logic [31:0] redir_tgt;
  logic [31:0] pc_inc;

  assign redir_tgt = {iRedirectPC[31:2], 2'b00};
  assign pc_inc    = pc_q + 32'd4;

  // Request and address depend only on state and PC.
  assign oIMemReq       = (state_q == FETCH) || (state_q == DROP);
  assign oIMemAddr      = {pc_q[31:2], 2'b00};
  assign oIF_ID_ppInstr = instr_q;
  assign oIF_ID_ppPC4   = pc4_q;
  assign oIF_ID_ppValid = valid_q;

  // State register, PC, IF/ID, stall buffer and saved redirect target.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      buf_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      buf_q   <= buf_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next-state: redirect beats stall; DROP waits out the wrong-path ack.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    buf_d   = buf_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (iRedirect) pc_d = redir_tgt;
      end
      FETCH: begin
        if (iRedirect) begin
          valid_d = 1'b0;
          if (iIMemAck) begin
            pc_d = redir_tgt;
          end else begin
            tgt_d   = redir_tgt;
            state_d = DROP;
          end
        end else if (iIMemAck && !iStall) begin
          instr_d = iIMemData;
          pc4_d   = pc_inc;
          valid_d = 1'b1;
          pc_d    = pc_inc;
        end else if (iIMemAck) begin
          buf_d   = iIMemData;
          state_d = BUF;
        end else if (!iStall) begin
          valid_d = 1'b0;
        end
      end
      BUF: begin
        if (iRedirect) begin
          valid_d = 1'b0;
          pc_d    = redir_tgt;
          state_d = FETCH;
        end else if (!iStall) begin
          instr_d = buf_q;
          pc4_d   = pc_inc;
          valid_d = 1'b1;
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end
      DROP: begin
        valid_d = 1'b0;
        if (iRedirect) tgt_d = redir_tgt;
        if (iIMemAck) begin
          pc_d    = iRedirect ? redir_tgt : tgt_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall buffer, redirect
// squash in DROP, PC wrap and asynchronous reset during a request.
module tb_fetch_stage;

  logic        iClk;
  logic        iReset_n;
  logic        iStall;
  logic        iRedirect;
  logic [31:0] iRedirectPC;
  logic        oIMemReq;
  logic [31:0] oIMemAddr;
  logic        iIMemAck;
  logic [31:0] iIMemData;
  logic [31:0] oIF_ID_ppInstr;
  logic [31:0] oIF_ID_ppPC4;
  logic        oIF_ID_ppValid;

  int n_vec = 0;
  int n_err = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .iClk           (iClk),
    .iReset_n       (iReset_n),
    .iStall         (iStall),
    .iRedirect      (iRedirect),
    .iRedirectPC    (iRedirectPC),
    .oIMemReq       (oIMemReq),
    .oIMemAddr      (oIMemAddr),
    .iIMemAck       (iIMemAck),
    .iIMemData      (iIMemData),
    .oIF_ID_ppInstr (oIF_ID_ppInstr),
    .oIF_ID_ppPC4   (oIF_ID_ppPC4),
    .oIF_ID_ppValid (oIF_ID_ppValid)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  assign iIMemData = mem(oIMemAddr);

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk_ifid(input string tag,
                          input logic [31:0] ins,
                          input logic [31:0] p4,
                          input logic v);
    chk({tag, ".instr"}, oIF_ID_ppInstr, ins);
    chk({tag, ".pc4"}, oIF_ID_ppPC4, p4);
    chk({tag, ".valid"}, {31'd0, oIF_ID_ppValid}, {31'd0, v});
  endtask

  task automatic chk_req(input string tag,
                         input logic r,
                         input logic [31:0] a);
    chk({tag, ".req"}, {31'd0, oIMemReq}, {31'd0, r});
    chk({tag, ".addr"}, oIMemAddr, a);
  endtask

  initial begin
    iReset_n    = 1'b0;
    iStall      = 1'b0;
    iRedirect   = 1'b0;
    iRedirectPC = '0;
    iIMemAck    = 1'b0;
    tick();
    tick();
    chk_req("rst", 1'b0, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);

    // Release: cycle 0 IDLE, cycle 1 FETCH at RESET_PC.
    iReset_n = 1'b1;
    chk_req("idle", 1'b0, 32'h0);
    tick();
    chk_req("fetch0", 1'b1, 32'h0);

    // Zero-wait streaming.
    iIMemAck = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_req($sformatf("strm%0d", i), 1'b1, 32'(4 * i));
      tick();
      chk_ifid($sformatf("strm%0d", i),
               mem(32'(4 * i)), 32'(4 * i + 4), 1'b1);
    end

    // Ack at 0x10 under stall: three frozen cycles in BUF.
    iStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_req($sformatf("buf%0d", i), 1'b0, 32'h10);
      chk_ifid($sformatf("buf%0d", i), mem(32'hC), 32'h10, 1'b1);
    end
    iStall   = 1'b0;
    iIMemAck = 1'b0;
    tick();
    chk_ifid("unbuf", mem(32'h10), 32'h14, 1'b1);
    chk_req("unbuf", 1'b1, 32'h14);

    // Stream 0x14..0x1C, then a bubble at 0x20.
    iIMemAck = 1'b1;
    tick();
    chk_ifid("after", mem(32'h14), 32'h18, 1'b1);
    tick();
    tick();
    chk_ifid("pre20", mem(32'h1C), 32'h20, 1'b1);
    iIMemAck = 1'b0;
    tick();
    chk_ifid("bubble", mem(32'h1C), 32'h20, 1'b0);
    chk_req("bubble", 1'b1, 32'h20);

    // Redirect to 0x100 while 0x20 is outstanding.
    iRedirect   = 1'b1;
    iRedirectPC = 32'h100;
    tick();
    iRedirect = 1'b0;
    chk_req("drop", 1'b1, 32'h20);
    tick();
    tick();
    chk_req("dropw", 1'b1, 32'h20);
    chk_ifid("dropw", mem(32'h1C), 32'h20, 1'b0);
    iIMemAck = 1'b1;
    tick();
    iIMemAck = 1'b0;
    chk_req("redir", 1'b1, 32'h100);
    chk_ifid("redir", mem(32'h1C), 32'h20, 1'b0);

    // Redirects in DROP: latest wins.
    iRedirect   = 1'b1;
    iRedirectPC = 32'h180;
    tick();
    iRedirectPC = 32'h100;
    tick();
    iRedirectPC = 32'h200;
    tick();
    iRedirect = 1'b0;
    iIMemAck  = 1'b1;
    tick();
    chk_req("twice", 1'b1, 32'h200);
    chk_ifid("twice", mem(32'h1C), 32'h20, 1'b0);

    // Redirect with stall and ack in FETCH: flush wins.
    tick();
    chk_ifid("s200", mem(32'h200), 32'h204, 1'b1);
    iRedirect   = 1'b1;
    iStall      = 1'b1;
    iRedirectPC = 32'h300;
    tick();
    iStall = 1'b0;
    chk_ifid("flush", mem(32'h200), 32'h204, 1'b0);
    chk_req("flush", 1'b1, 32'h300);

    // Low target bits ignored; PC+4 wraps.
    iRedirectPC = 32'hFFFF_FFFF;
    tick();
    iRedirect = 1'b0;
    chk_req("top", 1'b1, 32'hFFFF_FFFC);
    tick();
    chk_ifid("wrap", mem(32'hFFFF_FFFC), 32'h0, 1'b1);
    chk_req("wrap", 1'b1, 32'h0);

    // DROP with redirect and ack in the same cycle.
    iIMemAck    = 1'b0;
    iRedirect   = 1'b1;
    iRedirectPC = 32'h40;
    tick();
    iRedirectPC = 32'h80;
    iIMemAck    = 1'b1;
    tick();
    iRedirect = 1'b0;
    iIMemAck  = 1'b0;
    chk_req("same", 1'b1, 32'h80);
    chk_ifid("same", mem(32'hFFFF_FFFC), 32'h0, 1'b0);

    // Reset while in DROP with a stale ack pending.
    iRedirect   = 1'b1;
    iRedirectPC = 32'h500;
    tick();
    iRedirect = 1'b0;
    iIMemAck  = 1'b1;
    iReset_n  = 1'b0;
    #1;
    chk_req("arst", 1'b0, 32'h0);
    chk_ifid("arst", 32'h0, 32'h0, 1'b0);
    tick();
    chk_ifid("arst2", 32'h0, 32'h0, 1'b0);
    iIMemAck = 1'b0;
    iReset_n = 1'b1;
    chk_req("rel", 1'b0, 32'h0);
    tick();
    chk_req("rel1", 1'b1, 32'h0);
    chk_ifid("rel1", 32'h0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
